// File: rtl/coef_pkg.sv
// Shared constants and types for the coefficient ROM readers.
// Holds the coefficient geometry and the reader FSM state encoding.
package coef_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 5;
    localparam int BIAS_DEPTH = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/bias_rom_reader_if.sv
// Coefficient stream bundle: valid/ready with index and last tags.
// master: m_valid, m_data, m_index, m_last out; m_ready in.
// slave:  the mirror image, used by the accumulate stage.
interface bias_rom_reader_if #(
    parameter int DATA_W = coef_pkg::DATA_W,
    parameter int ADDR_W = coef_pkg::ADDR_W
) ();

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_index;
    logic              m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/coef_skid_fifo.sv
// Two-entry FIFO holding {index, data} words returned by the ROM.
// Ports: clk, reset (async, active-high), push_i/din_i write side,
// pop_i read side, dout_o = current head, count_o = occupancy 0..2.
// The caller never pushes into a full FIFO without popping.
module coef_skid_fifo #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/bias_rom_reader.sv
// Streams the bias coefficients out of the synchronous pROM as a
// valid/ready stream tagged with index and last.
// Ports: clk, reset (async, active-high), start pulse, busy, done pulse,
// rom_ce/rom_oce/rom_ad/rom_dout to the ROM, m = stream master.
module bias_rom_reader #(
    parameter int DATA_W = coef_pkg::DATA_W,
    parameter int ADDR_W = coef_pkg::ADDR_W,
    parameter int DEPTH  = coef_pkg::BIAS_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout,
    bias_rom_reader_if.master m
);

    import coef_pkg::*;

    localparam int                EW     = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] END_A  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] tag_q;

    logic              issue;
    logic              pop;
    logic              valid;
    logic [1:0]        count;
    logic [2:0]        room;
    logic              fifo_push;
    logic              fifo_pop;
    logic [EW-1:0]     head;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;

    // Words already committed once this cycle's pop is taken; a new
    // read may go out only if that leaves a free slot for its data.
    assign room = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    addr_d  = '0;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (addr_q >= END_A) begin
                    state_d = DRAIN;
                end else if (room <= 3'd1) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if ((count == 2'd0) && !inflight_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inflight_q <= issue;
            if (issue) begin
                tag_q <= addr_q;
            end
        end
    end

    assign rom_ce  = issue;
    assign rom_oce = 1'b1;
    assign rom_ad  = addr_q;

    // An empty FIFO lets the returning ROM word straight through, so
    // the first word is visible the cycle its data arrives.
    assign valid     = (count != 2'd0) || inflight_q;
    assign pop       = valid && m.m_ready;
    assign fifo_pop  = pop && (count != 2'd0);
    assign fifo_push = inflight_q && !((count == 2'd0) && pop);

    coef_skid_fifo #(
        .W (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ({tag_q, rom_dout}),
        .dout_o  (head),
        .count_o (count)
    );

    always_comb begin
        out_data  = '0;
        out_index = '0;
        if (count != 2'd0) begin
            {out_index, out_data} = head;
        end else if (inflight_q) begin
            out_index = tag_q;
            out_data  = rom_dout;
        end
    end

    assign m.m_valid = valid;
    assign m.m_data  = out_data;
    assign m.m_index = out_index;
    assign m.m_last  = valid && (out_index == LAST_A);

endmodule

// File: tb/tb_bias_rom_reader.sv
// Randomised scoreboard bench for bias_rom_reader with a pROM model.
// Expected words are queued per pass; a monitor pops them on handshakes.
module tb_bias_rom_reader;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 30;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          rom_ce;
    logic          rom_oce;
    logic [AW-1:0] rom_ad;
    logic [DW-1:0] rom_dout = '0;

    bias_rom_reader_if m_if ();

    bias_rom_reader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rom_ce   (rom_ce),
        .rom_oce  (rom_oce),
        .rom_ad   (rom_ad),
        .rom_dout (rom_dout),
        .m        (m_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom_tbl [32];

    always @(posedge clk) begin
        if (rom_ce) rom_dout <= rom_tbl[rom_ad];
    end

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] i;
        logic          l;
    } exp_t;

    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;
    int mode       = 0;
    int occ_tb     = 0;
    int done_cnt   = 0;
    int hs_cnt     = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push_pass();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('{rom_tbl[i], AW'(i), (i == DEPTH - 1)});
        end
    endtask

    task automatic pulse_start(input bit accept);
        if (accept) push_pass();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name,
                             output int n);
        n = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                n = k + 1;
                return;
            end
        end
        compared++;
        mismatched++;
        $display("FAIL %s: no done within %0d cycles", name, budget);
    endtask

    // m_ready driver: 0 always-ready, 1 pattern 1,0,0,1, 2 random, 3 held low
    initial begin
        int ph;
        ph = 0;
        m_if.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_if.m_ready = 1'b1;
                1:       m_if.m_ready = (ph % 4 == 0) || (ph % 4 == 3);
                2:       m_if.m_ready = 1'($urandom % 2);
                default: m_if.m_ready = 1'b0;
            endcase
            ph++;
        end
    end

    // Monitor: scoreboard, stall stability, issue room and address range
    initial begin
        logic          mpop;
        logic          prev_stall;
        logic [DW-1:0] prev_d;
        logic [AW-1:0] prev_i;
        exp_t          e;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_i     = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                occ_tb     = 0;
                prev_stall = 1'b0;
            end else begin
                mpop = m_if.m_valid && m_if.m_ready;
                if (done) done_cnt++;
                if (rom_ce) begin
                    compared++;
                    if (occ_tb - (mpop ? 1 : 0) >= 2) begin
                        mismatched++;
                        $display("FAIL issue_room: ce with %0d words held, pop %0b",
                                 occ_tb, mpop);
                    end
                    compared++;
                    if (rom_ad >= AW'(DEPTH)) begin
                        mismatched++;
                        $display("FAIL issue_addr: rom_ad %0d want < %0d",
                                 rom_ad, DEPTH);
                    end
                end
                if (prev_stall) begin
                    chk("stall_data", 32'(m_if.m_data), 32'(prev_d));
                    chk("stall_index", 32'(m_if.m_index), 32'(prev_i));
                end
                if (mpop) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL extra_word: idx %0d data %0h unexpected",
                                 m_if.m_index, m_if.m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", {11'd0, m_if.m_data, m_if.m_index, m_if.m_last},
                            {11'd0, e.d, e.i, e.l});
                    end
                end
                occ_tb = occ_tb + (rom_ce ? 1 : 0) - (mpop ? 1 : 0);
                prev_stall = m_if.m_valid && !m_if.m_ready;
                prev_d     = m_if.m_data;
                prev_i     = m_if.m_index;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int hs0;
        int d0;
        int t_last;
        int t_done;
        bit found;
        for (int i = 0; i < 32; i++) rom_tbl[i] = 16'($urandom);
        rom_tbl[0]  = 16'hFEA5;
        rom_tbl[1]  = 16'h0151;
        rom_tbl[2]  = 16'hF897;
        rom_tbl[16] = 16'hF9DC;
        rom_tbl[29] = 16'hF7DC;

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ce", 32'(rom_ce), 32'd0);
        chk("rst_oce", 32'(rom_oce), 32'd1);
        chk("rst_ad", 32'(rom_ad), 32'd0);
        chk("rst_valid", 32'(m_if.m_valid), 32'd0);
        chk("rst_data", 32'(m_if.m_data), 32'd0);
        chk("rst_index", 32'(m_if.m_index), 32'd0);
        chk("rst_last", 32'(m_if.m_last), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Pass 1: always ready, cycle-exact timing
        mode = 0;
        repeat (2) @(posedge clk);
        hs0    = hs_cnt;
        t_last = -1;
        t_done = -1;
        pulse_start(1'b1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("c1_ce", 32'(rom_ce), 32'd1);
                chk("c1_ad", 32'(rom_ad), 32'd0);
                chk("c1_busy", 32'(busy), 32'd1);
            end
            if (c == 2) begin
                chk("c2_valid", 32'(m_if.m_valid), 32'd1);
                chk("c2_index", 32'(m_if.m_index), 32'd0);
                chk("c2_data", 32'(m_if.m_data), 32'hFEA5);
            end
            if (c == 3) chk("c3_data", 32'(m_if.m_data), 32'h0151);
            if (c == 4) chk("c4_data", 32'(m_if.m_data), 32'hF897);
            if (c == 18) chk("c18_data", 32'(m_if.m_data), 32'hF9DC);
            if (m_if.m_valid && m_if.m_index == 5'd29 && t_last < 0) begin
                t_last = c;
                chk("w29_data", 32'(m_if.m_data), 32'hF7DC);
                chk("w29_last", 32'(m_if.m_last), 32'd1);
            end
            if (done && t_done < 0) begin
                t_done = c;
                chk("done_busy", 32'(busy), 32'd0);
            end
        end
        chk("idx29_cycle", 32'(t_last), 32'd31);
        chk("done_cycle", 32'(t_done), 32'd32);
        chk("p1_handshakes", 32'(hs_cnt - hs0), 32'd30);
        chk("p1_drained", 32'(exp_q.size()), 32'd0);

        // Pass 2: ready pattern 1,0,0,1
        mode = 1;
        repeat (2) @(posedge clk);
        hs0 = hs_cnt;
        pulse_start(1'b1);
        wait_done(400, "pat_done", n);
        chk("pat_handshakes", 32'(hs_cnt - hs0), 32'd30);
        chk("pat_drained", 32'(exp_q.size()), 32'd0);

        // Pass 3: ready held low for 10 cycles
        mode = 3;
        repeat (3) @(posedge clk);
        pulse_start(1'b1);
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n += rom_ce ? 1 : 0;
        end
        chk("stall_ce_count", 32'(n), 32'd2);
        chk("stall_valid", 32'(m_if.m_valid), 32'd1);
        chk("stall_head", 32'(m_if.m_data), 32'hFEA5);
        mode = 0;
        wait_done(400, "stall_done", n);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Pass 4: second start mid-run is ignored
        mode = 2;
        repeat (2) @(posedge clk);
        d0 = done_cnt;
        pulse_start(1'b1);
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(400, "restart_done", n);
        repeat (5) @(negedge clk);
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        chk("restart_drained", 32'(exp_q.size()), 32'd0);

        // Pass 5: reset at index 12 with a read in flight
        mode = 0;
        repeat (2) @(posedge clk);
        pulse_start(1'b1);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_if.m_valid && m_if.m_index == 5'd12) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_idx12", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_ce", 32'(rom_ce), 32'd0);
        chk("mid_ad", 32'(rom_ad), 32'd0);
        chk("mid_valid", 32'(m_if.m_valid), 32'd0);
        chk("mid_data", 32'(m_if.m_data), 32'd0);
        chk("mid_index", 32'(m_if.m_index), 32'd0);
        chk("mid_last", 32'(m_if.m_last), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulse_start(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("after_rst_valid", 32'(m_if.m_valid), 32'd1);
        chk("after_rst_index", 32'(m_if.m_index), 32'd0);
        chk("after_rst_data", 32'(m_if.m_data), 32'hFEA5);
        wait_done(400, "after_rst_done", n);
        chk("after_rst_drained", 32'(exp_q.size()), 32'd0);

        // Pass 6/7: start in the cycle after done, then a random pass
        pulse_start(1'b1);
        wait_done(400, "b2b_done", n);
        chk("b2b_done_cycle", 32'(n), 32'd32);
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);
        mode = 2;
        pulse_start(1'b1);
        wait_done(400, "rand_done", n);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
